// File: rtl/fx_pkg.sv
// Shared types and default widths for the effect-chain sequencer.
package fx_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned ADDR_WIDTH_DEF = 13;
  localparam int unsigned NUM_FX_DEF     = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_RUN    = 3'd2,
    ST_WRITE  = 3'd3,
    ST_OUTPUT = 3'd4
  } fx_state_e;

endpackage

// File: rtl/fx_sequencer_if.sv
// Sample, effect-slot and smart_ram signals of the sequencer; master is the sequencer side.
interface fx_sequencer_if import fx_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned NUM_FX     = NUM_FX_DEF
);

  logic                         sample_valid;
  logic [DATA_WIDTH-1:0]        sample_in;
  logic [NUM_FX-1:0]            fx_cs;
  logic [NUM_FX-1:0]            fx_done;
  logic [NUM_FX*DATA_WIDTH-1:0] fx_data_out;
  logic [NUM_FX-1:0]            fx_sram_rd;
  logic [NUM_FX*ADDR_WIDTH-1:0] fx_sram_offset;
  logic [NUM_FX-1:0]            fx_my_turn;
  logic [DATA_WIDTH-1:0]        fx_data_in;
  logic [NUM_FX-1:0]            fx_sram_read_finish;
  logic                         sram_rd;
  logic [ADDR_WIDTH-1:0]        sram_offset;
  logic                         sram_read_finish;
  logic                         sram_wr;
  logic [DATA_WIDTH-1:0]        sram_data_out;
  logic                         sram_write_finish;
  logic [DATA_WIDTH-1:0]        sample_out;
  logic                         sample_out_valid;
  logic                         busy;
  logic                         overrun;
  logic [NUM_FX-1:0]            fx_fault;

  modport master (
    input  sample_valid, sample_in, fx_cs, fx_done, fx_data_out, fx_sram_rd,
           fx_sram_offset, sram_read_finish, sram_write_finish,
    output fx_my_turn, fx_data_in, fx_sram_read_finish, sram_rd, sram_offset,
           sram_wr, sram_data_out, sample_out, sample_out_valid, busy, overrun,
           fx_fault
  );

  modport slave (
    output sample_valid, sample_in, fx_cs, fx_done, fx_data_out, fx_sram_rd,
           fx_sram_offset, sram_read_finish, sram_write_finish,
    input  fx_my_turn, fx_data_in, fx_sram_read_finish, sram_rd, sram_offset,
           sram_wr, sram_data_out, sample_out, sample_out_valid, busy, overrun,
           fx_fault
  );

endinterface

// File: rtl/fx_next_sel.sv
// Combinational search for the lowest enabled slot index at or above start.
module fx_next_sel import fx_pkg::*; #(
  parameter int unsigned NUM_FX = NUM_FX_DEF,
  parameter int unsigned IDX_W  = $clog2(NUM_FX + 1)
) (
  input  logic [NUM_FX-1:0] cs,
  input  logic [IDX_W-1:0]  start,
  output logic              found,
  output logic [IDX_W-1:0]  index
);

  // Scan downward so the last hit is the lowest qualifying index.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = int'(NUM_FX) - 1; k >= 0; k--) begin
      if (cs[k] && (IDX_W'(k) >= start)) begin
        found = 1'b1;
        index = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/fx_sequencer.sv
// Runs each ADC sample through the enabled effect slots in order, then writes the dry sample
// to the delay line and emits the processed sample. FX_SEQ_TIMEOUT_EN adds a per-turn timeout.
module fx_sequencer import fx_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned NUM_FX     = NUM_FX_DEF,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic          clk,
  input  logic          rst,
  fx_sequencer_if.master bus
);

  localparam int unsigned IDX_W  = $clog2(NUM_FX + 1);
  localparam int unsigned SLOT_W = (NUM_FX > 1) ? $clog2(NUM_FX) : 1;

  fx_state_e             state_q, state_nxt;
  logic [IDX_W-1:0]      idx_q, idx_nxt;
  logic [SLOT_W-1:0]     slot;
  logic [DATA_WIDTH-1:0] chain_q, chain_nxt;
  logic [DATA_WIDTH-1:0] dry_q, dry_nxt;
  logic [DATA_WIDTH-1:0] out_q, out_nxt;
  logic [NUM_FX-1:0]     turn_q, turn_nxt;
  logic                  wr_q, wr_nxt;
  logic                  out_vld_q, out_vld_nxt;
  logic                  overrun_q, overrun_nxt;
  logic                  busy_q, busy_nxt;
  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic [DATA_WIDTH-1:0] slot_data [NUM_FX];
  logic [ADDR_WIDTH-1:0] slot_off  [NUM_FX];
  logic                  rd_c;
  logic [ADDR_WIDTH-1:0] off_c;
  logic [NUM_FX-1:0]     rfin_c;

`ifdef FX_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic [NUM_FX-1:0]     fault_q, fault_nxt;
`endif

  assign slot = SLOT_W'(idx_q);

  // Unpack the flat per-slot buses.
  always_comb begin
    for (int k = 0; k < int'(NUM_FX); k++) begin
      slot_data[k] = bus.fx_data_out[k*DATA_WIDTH +: DATA_WIDTH];
      slot_off[k]  = bus.fx_sram_offset[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  fx_next_sel #(
    .NUM_FX (NUM_FX),
    .IDX_W  (IDX_W)
  ) u_next_sel (
    .cs    (bus.fx_cs),
    .start (idx_q),
    .found (sel_found),
    .index (sel_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      chain_q   <= '0;
      dry_q     <= '0;
      out_q     <= '0;
      turn_q    <= '0;
      wr_q      <= 1'b0;
      out_vld_q <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FX_SEQ_TIMEOUT_EN
      cnt_q     <= '0;
      fault_q   <= '0;
`endif
    end else begin
      state_q   <= state_nxt;
      idx_q     <= idx_nxt;
      chain_q   <= chain_nxt;
      dry_q     <= dry_nxt;
      out_q     <= out_nxt;
      turn_q    <= turn_nxt;
      wr_q      <= wr_nxt;
      out_vld_q <= out_vld_nxt;
      overrun_q <= overrun_nxt;
      busy_q    <= busy_nxt;
`ifdef FX_SEQ_TIMEOUT_EN
      cnt_q     <= cnt_nxt;
      fault_q   <= fault_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state_q;
    idx_nxt     = idx_q;
    chain_nxt   = chain_q;
    dry_nxt     = dry_q;
    out_nxt     = out_q;
    turn_nxt    = turn_q;
    wr_nxt      = wr_q;
    out_vld_nxt = 1'b0;
    // A sample arriving while a previous one is in flight is dropped.
    overrun_nxt = overrun_q | (bus.sample_valid && (state_q != ST_IDLE));
`ifdef FX_SEQ_TIMEOUT_EN
    cnt_nxt     = cnt_q;
    fault_nxt   = fault_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.sample_valid) begin
          chain_nxt = bus.sample_in;
          dry_nxt   = bus.sample_in;
          idx_nxt   = '0;
          state_nxt = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (sel_found) begin
          idx_nxt   = sel_idx;
          turn_nxt  = NUM_FX'(1) << SLOT_W'(sel_idx);
          state_nxt = ST_RUN;
`ifdef FX_SEQ_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end else begin
          wr_nxt    = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_RUN: begin
        if (bus.fx_done[slot]) begin
          turn_nxt  = '0;
          chain_nxt = slot_data[slot];
          idx_nxt   = idx_q + IDX_W'(1);
          state_nxt = ST_SELECT;
`ifdef FX_SEQ_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Skip the stalled slot; the chain value passes through unchanged.
          fault_nxt[slot] = 1'b1;
          turn_nxt        = '0;
          idx_nxt         = idx_q + IDX_W'(1);
          state_nxt       = ST_SELECT;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
`endif
        end
      end
      ST_WRITE: begin
        if (bus.sram_write_finish) begin
          wr_nxt    = 1'b0;
          state_nxt = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        out_nxt     = chain_q;
        out_vld_nxt = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // smart_ram read port belongs to the slot holding the turn, and only during RUN.
  always_comb begin
    rd_c   = 1'b0;
    off_c  = '0;
    rfin_c = '0;
    if (state_q == ST_RUN) begin
      rd_c         = bus.fx_sram_rd[slot];
      off_c        = slot_off[slot];
      rfin_c[slot] = bus.sram_read_finish;
    end
  end

  assign bus.sram_rd             = rd_c;
  assign bus.sram_offset         = off_c;
  assign bus.fx_sram_read_finish = rfin_c;
  assign bus.fx_my_turn          = turn_q;
  assign bus.fx_data_in          = chain_q;
  assign bus.sram_wr             = wr_q;
  assign bus.sram_data_out       = dry_q;
  assign bus.sample_out          = out_q;
  assign bus.sample_out_valid    = out_vld_q;
  assign bus.busy                = busy_q;
  assign bus.overrun             = overrun_q;
`ifdef FX_SEQ_TIMEOUT_EN
  assign bus.fx_fault            = fault_q;
`else
  assign bus.fx_fault            = '0;
`endif

endmodule

// File: tb/tb_fx_sequencer.sv
// Directed bench for fx_sequencer: bypass, chaining, read routing, overrun, timeout and reset.
module tb_fx_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fx_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(13), .NUM_FX(4)) bus ();

  fx_sequencer #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (13),
    .NUM_FX     (4),
    .TIMEOUT    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // smart_ram write side: acknowledge a write one half-cycle after it is seen.
  initial begin
    bus.sram_write_finish = 1'b0;
    forever begin
      @(negedge clk);
      bus.sram_write_finish = bus.sram_wr;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_slot_data(input int k, input logic [15:0] v);
    bus.fx_data_out[k*16 +: 16] = v;
  endtask

  task automatic send_sample(input logic [15:0] v);
    @(posedge clk); #1;
    bus.sample_valid = 1'b1;
    bus.sample_in    = v;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic wait_turn(output logic [3:0] t);
    t = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.fx_my_turn != 4'b0) begin
        t = bus.fx_my_turn;
        return;
      end
    end
    total++; bad++;
    $display("FAIL wait_turn: no grant within 50 cycles");
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.sample_out_valid) return;
    end
    total++; bad++;
    $display("FAIL wait_valid: no sample_out_valid within 60 cycles");
  endtask

  task automatic test_reset();
    rst                  = 1'b0;
    bus.sample_valid     = 1'b0;
    bus.sample_in        = '0;
    bus.fx_cs            = '0;
    bus.fx_done          = '0;
    bus.fx_data_out      = '0;
    bus.fx_sram_rd       = '0;
    bus.fx_sram_offset   = '0;
    bus.sram_read_finish = 1'b0;
    #1;
    total++; if (bus.fx_my_turn !== 4'b0) begin bad++; $display("FAIL reset_turn: got %b want 0000", bus.fx_my_turn); end
    total++; if (bus.sram_wr !== 1'b0) begin bad++; $display("FAIL reset_sram_wr: got %b want 0", bus.sram_wr); end
    total++; if (bus.sample_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.sample_out_valid); end
    total++; if (bus.sample_out !== 16'h0) begin bad++; $display("FAIL reset_sample_out: got %h want 0000", bus.sample_out); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    total++; if (bus.fx_fault !== 4'b0) begin bad++; $display("FAIL reset_fault: got %b want 0000", bus.fx_fault); end
    total++; if (bus.fx_data_in !== 16'h0) begin bad++; $display("FAIL reset_chain: got %h want 0000", bus.fx_data_in); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_bypass();
    bus.fx_cs            = 4'b0000;
    bus.fx_sram_rd       = 4'b1111;
    bus.sram_read_finish = 1'b1;
    send_sample(16'h1234);
    @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL bypass_busy: got %b want 1", bus.busy); end
    total++; if (bus.sram_wr !== 1'b0) begin bad++; $display("FAIL bypass_wr_early: got %b want 0", bus.sram_wr); end
    @(negedge clk);
    total++; if (bus.sram_wr !== 1'b1) begin bad++; $display("FAIL bypass_wr: got %b want 1", bus.sram_wr); end
    total++; if (bus.sram_data_out !== 16'h1234) begin bad++; $display("FAIL bypass_wr_data: got %h want 1234", bus.sram_data_out); end
    total++; if (bus.sram_rd !== 1'b0) begin bad++; $display("FAIL bypass_rd_in_write: got %b want 0", bus.sram_rd); end
    total++; if (bus.fx_sram_read_finish !== 4'b0) begin bad++; $display("FAIL bypass_rfin: got %b want 0000", bus.fx_sram_read_finish); end
    @(negedge clk);
    total++; if (bus.sample_out_valid !== 1'b0) begin bad++; $display("FAIL bypass_valid_early: got %b want 0", bus.sample_out_valid); end
    @(negedge clk);
    total++; if (bus.sample_out_valid !== 1'b1) begin bad++; $display("FAIL bypass_latency: valid got %b want 1 at cycle 4", bus.sample_out_valid); end
    total++; if (bus.sample_out !== 16'h1234) begin bad++; $display("FAIL bypass_out: got %h want 1234", bus.sample_out); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL bypass_idle: busy got %b want 0", bus.busy); end
    @(negedge clk);
    total++; if (bus.sample_out_valid !== 1'b0) begin bad++; $display("FAIL bypass_pulse: got %b want 0", bus.sample_out_valid); end
    bus.fx_sram_rd       = '0;
    bus.sram_read_finish = 1'b0;
  endtask

  task automatic test_chain();
    logic [3:0] t;
    int cyc;
    bus.fx_cs = 4'b0101;
    set_slot_data(0, 16'h0100);
    set_slot_data(1, 16'hDEAD);
    set_slot_data(2, 16'h0200);
    set_slot_data(3, 16'hBEEF);
    send_sample(16'h0055);
    wait_turn(t);
    total++; if (t !== 4'b0001) begin bad++; $display("FAIL chain_grant0: got %b want 0001", t); end
    total++; if (bus.fx_data_in !== 16'h0055) begin bad++; $display("FAIL chain_in0: got %h want 0055", bus.fx_data_in); end
    bus.fx_done = 4'b0001;
    @(posedge clk); #1;
    bus.fx_done = 4'b0000;
    wait_turn(t);
    total++; if (t !== 4'b0100) begin bad++; $display("FAIL chain_grant2: got %b want 0100", t); end
    total++; if (bus.fx_data_in !== 16'h0100) begin bad++; $display("FAIL chain_in2: got %h want 0100", bus.fx_data_in); end
    bus.fx_done = 4'b1011;
    @(negedge clk);
    total++; if (bus.fx_my_turn !== 4'b0100) begin bad++; $display("FAIL chain_foreign_done: turn got %b want 0100", bus.fx_my_turn); end
    total++; if (bus.fx_data_in !== 16'h0100) begin bad++; $display("FAIL chain_foreign_data: got %h want 0100", bus.fx_data_in); end
    bus.fx_done = 4'b0100;
    @(posedge clk); #1;
    bus.fx_done = 4'b0000;
    wait_valid(cyc);
    total++; if (bus.sample_out !== 16'h0200) begin bad++; $display("FAIL chain_out: got %h want 0200", bus.sample_out); end
  endtask

  task automatic test_sram_route();
    logic [3:0] t;
    int cyc;
    bus.fx_cs = 4'b0010;
    set_slot_data(1, 16'h5555);
    send_sample(16'h0321);
    wait_turn(t);
    total++; if (t !== 4'b0010) begin bad++; $display("FAIL route_grant: got %b want 0010", t); end
    bus.fx_sram_rd                = 4'b1010;
    bus.fx_sram_offset[13 +: 13]  = 13'h0F00;
    bus.fx_sram_offset[39 +: 13]  = 13'h0ABC;
    bus.sram_read_finish          = 1'b1;
    #1;
    total++; if (bus.sram_rd !== 1'b1) begin bad++; $display("FAIL route_rd: got %b want 1", bus.sram_rd); end
    total++; if (bus.sram_offset !== 13'h0F00) begin bad++; $display("FAIL route_offset: got %h want 0f00", bus.sram_offset); end
    total++; if (bus.fx_sram_read_finish !== 4'b0010) begin bad++; $display("FAIL route_finish: got %b want 0010", bus.fx_sram_read_finish); end
    bus.fx_sram_rd = 4'b1000;
    #1;
    total++; if (bus.sram_rd !== 1'b0) begin bad++; $display("FAIL route_other_slot: got %b want 0", bus.sram_rd); end
    bus.fx_sram_rd       = '0;
    bus.sram_read_finish = 1'b0;
    bus.fx_done          = 4'b0010;
    @(posedge clk); #1;
    bus.fx_done = 4'b0000;
    wait_valid(cyc);
    total++; if (bus.sample_out !== 16'h5555) begin bad++; $display("FAIL route_out: got %h want 5555", bus.sample_out); end
  endtask

  task automatic test_overrun();
    logic [3:0]  t;
    logic [15:0] last;
    int          nv;
    bus.fx_cs = 4'b0001;
    set_slot_data(0, 16'h3333);
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL overrun_pre: got %b want 0", bus.overrun); end
    send_sample(16'h1111);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b1;
    bus.sample_in    = 16'h2222;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    @(negedge clk);
    t = bus.fx_my_turn;
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", bus.overrun); end
    total++; if (bus.fx_data_in !== 16'h1111) begin bad++; $display("FAIL overrun_chain: got %h want 1111", bus.fx_data_in); end
    total++; if (t !== 4'b0001) begin bad++; $display("FAIL overrun_turn: got %b want 0001", t); end
    bus.fx_done = 4'b0001;
    @(posedge clk); #1;
    bus.fx_done = 4'b0000;
    nv   = 0;
    last = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.sample_out_valid) begin
        nv++;
        last = bus.sample_out;
      end
    end
    total++; if (nv !== 1) begin bad++; $display("FAIL overrun_count: got %0d valids want 1", nv); end
    total++; if (last !== 16'h3333) begin bad++; $display("FAIL overrun_out: got %h want 3333", last); end
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b want 1", bus.overrun); end
  endtask

  task automatic test_timeout();
    logic [3:0] t;
    int cyc;
    bus.fx_cs = 4'b0100;
    set_slot_data(2, 16'h0999);
    send_sample(16'h0ABC);
    wait_turn(t);
    total++; if (t !== 4'b0100) begin bad++; $display("FAIL tmo_grant: got %b want 0100", t); end
    // Dropping the enable mid-turn must not end the turn.
    bus.fx_cs = 4'b0000;
`ifdef FX_SEQ_TIMEOUT_EN
    repeat (7) @(negedge clk);
    total++; if (bus.fx_my_turn !== 4'b0100) begin bad++; $display("FAIL tmo_hold: turn got %b want 0100", bus.fx_my_turn); end
    total++; if (bus.fx_fault !== 4'b0000) begin bad++; $display("FAIL tmo_early: fault got %b want 0000", bus.fx_fault); end
    @(negedge clk);
    total++; if (bus.fx_my_turn !== 4'b0000) begin bad++; $display("FAIL tmo_release: turn got %b want 0000", bus.fx_my_turn); end
    total++; if (bus.fx_fault !== 4'b0100) begin bad++; $display("FAIL tmo_fault: got %b want 0100", bus.fx_fault); end
    wait_valid(cyc);
    total++; if (bus.sample_out !== 16'h0ABC) begin bad++; $display("FAIL tmo_out: got %h want 0abc", bus.sample_out); end
    total++; if (bus.fx_fault !== 4'b0100) begin bad++; $display("FAIL tmo_sticky: got %b want 0100", bus.fx_fault); end
`else
    repeat (20) @(negedge clk);
    total++; if (bus.fx_my_turn !== 4'b0100) begin bad++; $display("FAIL wait_hold: turn got %b want 0100", bus.fx_my_turn); end
    total++; if (bus.fx_fault !== 4'b0000) begin bad++; $display("FAIL wait_fault: got %b want 0000", bus.fx_fault); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL wait_busy: got %b want 1", bus.busy); end
    bus.fx_done = 4'b0100;
    @(posedge clk); #1;
    bus.fx_done = 4'b0000;
    wait_valid(cyc);
    total++; if (bus.sample_out !== 16'h0999) begin bad++; $display("FAIL wait_out: got %h want 0999", bus.sample_out); end
`endif
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] t;
    int cyc, nv, ng;
    bus.fx_cs = 4'b0001;
    set_slot_data(0, 16'h4444);
    send_sample(16'h7777);
    wait_turn(t);
    rst = 1'b0;
    #1;
    total++; if (bus.fx_my_turn !== 4'b0) begin bad++; $display("FAIL rstrun_turn: got %b want 0000", bus.fx_my_turn); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstrun_busy: got %b want 0", bus.busy); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL rstrun_overrun: got %b want 0", bus.overrun); end
    total++; if (bus.fx_fault !== 4'b0) begin bad++; $display("FAIL rstrun_fault: got %b want 0000", bus.fx_fault); end
    total++; if (bus.fx_data_in !== 16'h0) begin bad++; $display("FAIL rstrun_chain: got %h want 0000", bus.fx_data_in); end
    total++; if (bus.sample_out !== 16'h0) begin bad++; $display("FAIL rstrun_out: got %h want 0000", bus.sample_out); end
    total++; if (bus.sram_wr !== 1'b0) begin bad++; $display("FAIL rstrun_wr: got %b want 0", bus.sram_wr); end
    @(negedge clk);
    rst = 1'b1;
    nv = 0;
    ng = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.sample_out_valid) nv++;
      if (bus.fx_my_turn != 4'b0) ng++;
    end
    total++; if (nv !== 0) begin bad++; $display("FAIL rstrun_abandon: got %0d valids want 0", nv); end
    total++; if (ng !== 0) begin bad++; $display("FAIL rstrun_grant: got %0d grant cycles want 0", ng); end
    bus.fx_cs = 4'b0000;
    send_sample(16'h0042);
    wait_valid(cyc);
    total++; if (cyc !== 4) begin bad++; $display("FAIL rstrun_latency: got %0d cycles want 4", cyc); end
    total++; if (bus.sample_out !== 16'h0042) begin bad++; $display("FAIL rstrun_next: got %h want 0042", bus.sample_out); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_chain();
    test_sram_route();
    test_overrun();
    test_timeout();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fx_sequencer.md
FX_SEQUENCER -- requirements
Module: fx_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 16, sample width; ADDR_WIDTH, default 13, smart_ram offset width; NUM_FX, default 4, number of effect slots; TIMEOUT, default 1023, max cycles per effect turn.
REQ-002 Ports SHALL be:
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-low reset.
- sample_valid, in, 1, one-cycle strobe for a new ADC sample.
- sample_in, in, DATA_WIDTH, signed sample.
- fx_cs, in, NUM_FX, per-slot enable.
- fx_done, in, NUM_FX, per-slot done pulse.
- fx_data_out, in, NUM_FX*DATA_WIDTH, per-slot result; slot k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- fx_sram_rd, in, NUM_FX, per-slot read request.
- fx_sram_offset, in, NUM_FX*ADDR_WIDTH, per-slot read offset.
- fx_my_turn, out, NUM_FX, one-hot turn grant.
- fx_data_in, out, DATA_WIDTH, current chain value, broadcast to all slots.
- fx_sram_read_finish, out, NUM_FX, routed read-finish.
- sram_rd, out, 1, to smart_ram.
- sram_offset, out, ADDR_WIDTH, to smart_ram.
- sram_read_finish, in, 1, from smart_ram.
- sram_wr, out, 1, delay-line write request.
- sram_data_out, out, DATA_WIDTH, write data.
- sram_write_finish, in, 1, from smart_ram.
- sample_out, out, DATA_WIDTH, processed sample.
- sample_out_valid, out, 1, one-cycle strobe.
- busy, out, 1, high whenever the FSM is not in IDLE.
- overrun, out, 1, sticky flag.
- fx_fault, out, NUM_FX, sticky per-slot timeout flags.

Function
REQ-003 The FSM SHALL have the states IDLE, SELECT, RUN, WRITE, OUTPUT.
REQ-004 In IDLE, sample_valid SHALL latch sample_in into the chain register and the dry register, set idx=0, and move to SELECT.
REQ-005 SELECT SHALL, in one cycle, find the lowest k>=idx with fx_cs[k]=1 and go to RUN with idx=k; if no such k exists, it SHALL go to WRITE.
REQ-006 In RUN, fx_my_turn SHALL be registered one-hot on idx, asserted the cycle after entry and held until fx_done[idx] is sampled.
REQ-007 On the edge that samples fx_done[idx]=1, the block SHALL clear fx_my_turn, load the chain register from slot idx, set idx=idx+1, and go to SELECT.
REQ-008 fx_done from any slot other than idx SHALL be ignored.
REQ-009 fx_data_in SHALL always equal the chain register.
REQ-010 SRAM read path, combinational:
- In RUN only: sram_rd=fx_sram_rd[idx], sram_offset=fx_sram_offset[idx], fx_sram_read_finish[idx]=sram_read_finish.
- In all other states, and for all other slots: sram_rd=0 and fx_sram_read_finish=0.
REQ-011 WRITE SHALL assert sram_wr=1 with sram_data_out=dry register until sram_write_finish, then go to OUTPUT; sram_rd SHALL be 0 in WRITE.
REQ-012 OUTPUT SHALL register sample_out=chain register, pulse sample_out_valid for one cycle, and return to IDLE.
REQ-013 A sample_valid outside IDLE SHALL set overrun, drop that sample, and leave the current sample unaffected.
REQ-014 An fx_cs bit deasserting during that slot's RUN SHALL NOT abort the turn.
REQ-015 Total latency with all slots disabled SHALL be 4 cycles plus the write handshake, measured from sample_valid to sample_out_valid.

Reset
REQ-016 While rst=0, all of the following SHALL be 0 asynchronously: state=IDLE, idx, fx_my_turn, sram_wr, sample_out, sample_out_valid, overrun, fx_fault, and the chain and dry registers.
REQ-017 A reset during RUN or WRITE SHALL abandon the sample with no sample_out_valid produced.

Configuration
REQ-018 With FX_SEQ_TIMEOUT_EN defined:
- A cycle counter SHALL run in RUN.
- After TIMEOUT cycles without fx_done[idx], the block SHALL set fx_fault[idx], clear fx_my_turn, keep the chain value, set idx=idx+1, and go to SELECT.
REQ-019 Without FX_SEQ_TIMEOUT_EN, RUN SHALL wait indefinitely, and fx_fault SHALL be tied to 0.

Structure
REQ-020 Package fx_pkg SHALL hold the FSM state enum and the defaults for DATA_WIDTH, ADDR_WIDTH and NUM_FX.
REQ-021 Sub-module fx_next_sel SHALL implement the combinational lowest-enabled-index-at-or-above-idx search, with found/index outputs.

Verification
REQ-022 fx_cs=0000, sample_in=0x1234 -> sram_wr with data 0x1234, then sample_out=0x1234 with a one-cycle valid.
REQ-023 fx_cs=0101; slot0 returns 0x0100 and slot2 returns 0x0200 -> grant order 0001 then 0100, fx_data_in=0x0100 during slot2, sample_out=0x0200.
REQ-024 Slot1 in RUN issues fx_sram_rd with offset 0x0F00 while slot3 also requests -> sram_offset=0x0F00, read-finish routed only to bit1, and slot3 request not forwarded.
REQ-025 A second sample_valid 3 cycles after the first -> overrun=1 and exactly one sample_out_valid.
REQ-026 With FX_SEQ_TIMEOUT_EN and TIMEOUT=8, slot2 never done -> fx_fault=0100 after 8 cycles, chain value passes through, and the sample completes.
REQ-027 rst asserted mid-RUN -> all outputs 0 immediately; after release, the next sample is processed normally.
